riscv_lsu: RTL and testbench
============================

RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk_i and rst_ni.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk_i, in, 1: clock; all state updates on rising edge.
- rst_ni, in, 1: synchronous active-low reset.
- core_req_i, in, 1: memory access request; core_addr_i comes from ALU result_o.
- core_we_i, in, 1: 1 = store, 0 = load.
- core_size_i, in, 3: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
- core_addr_i, in, 32: byte address.
- core_wd_i, in, 32: store data.
- core_rd_o, out, 32: load data, extended to 32 bits.
- core_stall_o, out, 1: core holds PC and inputs while 1.
- core_misalign_o, out, 1: misaligned-access flag.
- mem_req_o, out, 1: data memory request.
- mem_we_o, out, 1: data memory write enable.
- mem_be_o, out, 4: byte enables.
- mem_addr_o, out, 32: word address {addr[31:2], 2'b00}.
- mem_wd_o, out, 32: write data, replicated per lane.
- mem_rd_i, in, 32: memory read word.
- mem_ready_i, in, 1: memory completes the held request in this cycle.

Function
REQ-003 SHALL implement a two-state FSM, IDLE and WAIT; reset state is IDLE.
REQ-004 IDLE, core_req_i=1, access not trapped: SHALL drive mem_req_o=1 and core_stall_o=1 combinationally, latch we, size, addr and wd, and go to WAIT.
REQ-005 WAIT: SHALL hold mem_req_o=1 and drive all mem_* outputs from the latched values.
REQ-006 WAIT with mem_ready_i=0: SHALL keep core_stall_o=1 and stay in WAIT; no timeout.
REQ-007 WAIT with mem_ready_i=1:
- core_stall_o=0 in that cycle.
- For loads, core_rd_o is valid in that cycle.
- Next state is IDLE.
REQ-008 Minimum access latency SHALL be 2 cycles: request cycle plus one WAIT cycle with mem_ready_i=1.
REQ-009 A new request SHALL be accepted only from IDLE; back-to-back accesses therefore take at least 2 cycles each.
REQ-010 core_req_i falling during WAIT SHALL NOT abort the transaction; it completes from the latched values.
REQ-011 Store lanes:
- B: mem_be_o = 4'b0001 << addr[1:0]; mem_wd_o = {4{wd[7:0]}}.
- H: mem_be_o = addr[1] ? 4'b1100 : 4'b0011; mem_wd_o = {2{wd[15:0]}}.
- W: mem_be_o = 4'b1111; mem_wd_o = wd.
REQ-012 Loads SHALL drive mem_be_o = 4'b1111.
REQ-013 Load extraction uses the latched addr[1:0]:
- B/BU: byte at offset, sign- or zero-extended.
- H/HU: half at addr[1], sign- or zero-extended.
- W: word unchanged.
REQ-014 core_rd_o SHALL be 0 whenever no load completes in the current cycle.
REQ-015 core_size_i values 3, 6 and 7 SHALL be treated as W.
REQ-016 mem_req_o, core_stall_o and core_misalign_o SHALL be 0 while idle with core_req_i=0.

Reset
REQ-017 rst_ni=0 at a clock edge SHALL force IDLE and clear all latched fields, including in the middle of a WAIT transaction.
REQ-018 After reset, and in any cycle with rst_ni=0, SHALL drive: mem_req_o=0, core_stall_o=0, core_rd_o=0, core_misalign_o=0, mem_be_o=0, mem_we_o=0.
REQ-019 A mem_ready_i pulse arriving after reset with no request outstanding SHALL be ignored.

Configuration
REQ-020 Macro LSU_MISALIGN_TRAP_EN defined: an access is misaligned if H/HU has addr[0]=1 or W has addr[1:0]!=0.
- Such an access issues no memory request and does not stall.
- core_misalign_o=1 combinationally for that cycle; FSM stays in IDLE.
REQ-021 Macro not defined:
- core_misalign_o is tied to 0.
- H/HU ignores addr[0]; W ignores addr[1:0].
- The access proceeds normally.

Verification
REQ-022 Store W, addr=0x100, wd=0xDEADBEEF, mem_ready_i on 2nd cycle -> mem_be_o=1111, mem_addr_o=0x100, mem_wd_o=0xDEADBEEF; stall 1 then 0.
REQ-023 Load B, addr=0x103, mem_rd_i=0x80FF1234 -> core_rd_o=0xFFFFFF80; same access as BU -> 0x00000080.
REQ-024 Store H, addr=0x22, wd=0x0000ABCD -> mem_be_o=1100, mem_wd_o=0xABCDABCD.
REQ-025 Load HU, addr=0x8, mem_ready_i held 0 for 5 cycles -> stall held for 6 cycles; core_rd_o valid only in the ready cycle.
REQ-026 rst_ni=0 during WAIT -> next cycle mem_req_o=0 and stall=0; a later stray mem_ready_i is ignored.
REQ-027 With LSU_MISALIGN_TRAP_EN, load W at addr=0x101 -> core_misalign_o=1, mem_req_o=0, stall=0; without the macro -> access proceeds with mem_addr_o=0x100.

Source files
------------

// File: rtl/riscv_lsu.sv
// Load/store unit: one outstanding data-memory access through a two-state IDLE/WAIT FSM.
// Optional macro LSU_MISALIGN_TRAP_EN rejects misaligned H/HU/W accesses with core_misalign_o.
module riscv_lsu (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_misalign_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
    } lsu_req_t;

    function automatic logic is_byte(input logic [2:0] s);
        return (s == 3'd0) || (s == 3'd4);
    endfunction

    function automatic logic is_half(input logic [2:0] s);
        return (s == 3'd1) || (s == 3'd5);
    endfunction

    // Sizes 2, 3, 6, 7 all behave as a full word.
    function automatic logic is_word(input logic [2:0] s);
        return !is_byte(s) && !is_half(s);
    endfunction

    function automatic logic [3:0] lane_be(input logic we, input logic [2:0] s,
                                           input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        if (we) begin
            if (is_byte(s))      be = 4'b0001 << off;
            else if (is_half(s)) be = off[1] ? 4'b1100 : 4'b0011;
        end
        return be;
    endfunction

    function automatic logic [31:0] lane_wd(input logic we, input logic [2:0] s,
                                            input logic [31:0] wd);
        logic [31:0] d;
        d = '0;
        if (we) begin
            if (is_byte(s))      d = {4{wd[7:0]}};
            else if (is_half(s)) d = {2{wd[15:0]}};
            else                 d = wd;
        end
        return d;
    endfunction

    // B/H sign-extend, BU/HU (size[2]=1) zero-extend.
    function automatic logic [31:0] load_ext(input logic [2:0] s, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic        sgn;
        logic [31:0] d;
        b   = word[8*off +: 8];
        h   = off[1] ? word[31:16] : word[15:0];
        sgn = !s[2];
        if (is_byte(s))      d = {{24{sgn & b[7]}}, b};
        else if (is_half(s)) d = {{16{sgn & h[15]}}, h};
        else                 d = word;
        return d;
    endfunction

    state_t   state;
    lsu_req_t cur;
    lsu_req_t in_req;
    lsu_req_t act;
    logic     trap;
    logic     issue;
    logic     busy;
    logic     active;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = (is_half(core_size_i) && core_addr_i[0]) ||
                  (is_word(core_size_i) && (core_addr_i[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    assign in_req = '{we: core_we_i, size: core_size_i, addr: core_addr_i, wd: core_wd_i};

    // Every output is qualified by rst_ni so a reset cycle is quiet even mid-transaction.
    assign issue  = rst_ni && (state == S_IDLE) && core_req_i && !trap;
    assign busy   = rst_ni && (state == S_WAIT);
    assign active = issue || busy;
    assign act    = busy ? cur : in_req;

    assign mem_req_o       = active;
    assign mem_we_o        = active && act.we;
    assign mem_be_o        = active ? lane_be(act.we, act.size, act.addr[1:0]) : 4'b0000;
    assign mem_addr_o      = active ? {act.addr[31:2], 2'b00} : 32'h0;
    assign mem_wd_o        = active ? lane_wd(act.we, act.size, act.wd) : 32'h0;
    assign core_stall_o    = issue || (busy && !mem_ready_i);
    assign core_misalign_o = rst_ni && (state == S_IDLE) && core_req_i && trap;
    assign core_rd_o       = (busy && mem_ready_i && !cur.we)
                             ? load_ext(cur.size, cur.addr[1:0], mem_rd_i) : 32'h0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= S_IDLE;
            cur   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (core_req_i && !trap) begin
                        cur   <= in_req;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_ready_i) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized bench for riscv_lsu against a transaction-level reference model.
// Honours LSU_MISALIGN_TRAP_EN the same way as the design when defined.
module tb_riscv_lsu;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_misalign_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    riscv_lsu dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
        .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
        .core_stall_o(core_stall_o), .core_misalign_o(core_misalign_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i),
        .mem_ready_i(mem_ready_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // 0 = byte, 1 = half, 2 = word
    function automatic int kind(input logic [2:0] s);
        if (s == 3'd0 || s == 3'd4) return 0;
        if (s == 3'd1 || s == 3'd5) return 1;
        return 2;
    endfunction

    function automatic bit m_trap(input logic [2:0] s, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (kind(s) == 1 && a[0]) || (kind(s) == 2 && a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] m_be(input logic we, input logic [2:0] s, input logic [31:0] a);
        int off;
        off = a % 4;
        if (!we) return 4'hF;
        case (kind(s))
            0: return 4'(1 << off);
            1: return (off >= 2) ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] s, input logic [31:0] wd);
        case (kind(s))
            0: return (wd & 32'hFF) * 32'h0101_0101;
            1: return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] s, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        bit sgn;
        sgn = (s == 3'd0) || (s == 3'd1);
        case (kind(s))
            0: begin
                v = (rd >> (8 * (a % 4))) & 32'hFF;
                if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            1: begin
                v = (rd >> (((a % 4) >= 2) ? 16 : 0)) & 32'hFFFF;
                if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    task automatic idle_check(input string tag);
        @(posedge clk_i); #1;
        core_req_i  = 1'b0;
        mem_ready_i = 1'($urandom % 2);
        mem_rd_i    = $urandom;
        #4;
        chk({tag, "_idle_req"}, 32'(mem_req_o), 32'd0);
        chk({tag, "_idle_stall"}, 32'(core_stall_o), 32'd0);
        chk({tag, "_idle_rd"}, core_rd_o, 32'd0);
        chk({tag, "_idle_mis"}, 32'(core_misalign_o), 32'd0);
    endtask

    // One full access: request cycle, nwait not-ready cycles, then the ready cycle.
    task automatic access(input logic we, input logic [2:0] s, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int nwait, input bit scramble);
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
        e_be = m_be(we, s, a);
        e_wd = m_wd(s, wd);
        e_rd = m_rd(s, a, rd);
        @(posedge clk_i); #1;
        core_req_i = 1'b1; core_we_i = we; core_size_i = s;
        core_addr_i = a; core_wd_i = wd;
        mem_ready_i = 1'($urandom % 2);
        mem_rd_i = $urandom;
        #4;
        if (m_trap(s, a)) begin
            chk("trap_mis", 32'(core_misalign_o), 32'd1);
            chk("trap_req", 32'(mem_req_o), 32'd0);
            chk("trap_stall", 32'(core_stall_o), 32'd0);
            idle_check("trap");
            return;
        end
        chk("req_mis", 32'(core_misalign_o), 32'd0);
        chk("req_req", 32'(mem_req_o), 32'd1);
        chk("req_stall", 32'(core_stall_o), 32'd1);
        chk("req_we", 32'(mem_we_o), 32'(we));
        chk("req_be", 32'(mem_be_o), 32'(e_be));
        chk("req_addr", mem_addr_o, a & 32'hFFFF_FFFC);
        if (we) chk("req_wd", mem_wd_o, e_wd);
        chk("req_rd", core_rd_o, 32'd0);
        for (int i = 0; i <= nwait; i++) begin
            @(posedge clk_i); #1;
            if (scramble) begin
                core_req_i  = 1'($urandom % 2);
                core_we_i   = 1'($urandom % 2);
                core_size_i = 3'($urandom);
                core_addr_i = $urandom;
                core_wd_i   = $urandom;
            end
            mem_ready_i = (i == nwait);
            mem_rd_i    = (i == nwait) ? rd : $urandom;
            #4;
            chk("w_req", 32'(mem_req_o), 32'd1);
            chk("w_stall", 32'(core_stall_o), (i == nwait) ? 32'd0 : 32'd1);
            chk("w_we", 32'(mem_we_o), 32'(we));
            chk("w_be", 32'(mem_be_o), 32'(e_be));
            chk("w_addr", mem_addr_o, a & 32'hFFFF_FFFC);
            if (we) chk("w_wd", mem_wd_o, e_wd);
            chk("w_rd", core_rd_o, (i == nwait && !we) ? e_rd : 32'd0);
        end
        idle_check("post");
    endtask

    initial begin
        rst_ni = 1'b0;
        core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'd2;
        core_addr_i = 32'h40; core_wd_i = 32'h1234_5678;
        mem_rd_i = 32'hFFFF_FFFF; mem_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #5;
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_stall", 32'(core_stall_o), 32'd0);
        chk("rst_rd", core_rd_o, 32'd0);
        chk("rst_mis", 32'(core_misalign_o), 32'd0);
        chk("rst_be", 32'(mem_be_o), 32'd0);
        chk("rst_we", 32'(mem_we_o), 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1; core_req_i = 1'b0;
        #4;
        chk("post_rst_req", 32'(mem_req_o), 32'd0);
        chk("post_rst_rd", core_rd_o, 32'd0);

        access(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
        access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0, 1'b0);
        access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_1234, 0, 1'b0);
        access(1'b1, 3'd1, 32'h22, 32'h0000_ABCD, 32'h0, 0, 1'b0);
        access(1'b0, 3'd5, 32'h8, 32'h0, 32'h9876_F00D, 5, 1'b0);
        access(1'b0, 3'd2, 32'h101, 32'h0, 32'hCAFE_0001, 0, 1'b0);
        access(1'b1, 3'd7, 32'h204, 32'h0BAD_F00D, 32'h0, 1, 1'b1);

        // Reset in the middle of a WAIT, then a stray ready pulse.
        @(posedge clk_i); #1;
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h300;
        mem_ready_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b0; mem_ready_i = 1'b1; mem_rd_i = 32'h5555_AAAA;
        #4;
        chk("mid_rst_req", 32'(mem_req_o), 32'd0);
        chk("mid_rst_stall", 32'(core_stall_o), 32'd0);
        chk("mid_rst_rd", core_rd_o, 32'd0);
        chk("mid_rst_be", 32'(mem_be_o), 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1; core_req_i = 1'b0; mem_ready_i = 1'b1;
        #4;
        chk("stray_req", 32'(mem_req_o), 32'd0);
        chk("stray_stall", 32'(core_stall_o), 32'd0);
        chk("stray_rd", core_rd_o, 32'd0);
        idle_check("stray");

        for (int n = 0; n < 200; n++) begin
            access(1'($urandom % 2), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), 1'($urandom % 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
